// File: rtl/bypass_pipeline.sv
// Result-tracking pipeline with a generalised forwarding/hazard network.
// Each stage holds one in-flight instruction; the youngest producer answers every source lookup.
module bypass_pipeline #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 3,
  parameter int NSRC         = 2,
  parameter int AW           = 5,
  parameter int FLUSH_STAGES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hold,
  input  logic                   flush,
  input  logic                   iss_valid,
  output logic                   iss_ready,
  input  logic                   iss_we,
  input  logic [AW-1:0]          iss_rd,
  input  logic [NSRC*AW-1:0]     src_addr,
  output logic [NSRC-1:0]        fwd_hit,
  output logic [NSRC*XLEN-1:0]   fwd_data,
  input  logic [DEPTH-1:0]       res_valid,
  input  logic [DEPTH*XLEN-1:0]  res_data,
  output logic                   wb_valid,
  output logic [AW-1:0]          wb_rd,
  output logic [XLEN-1:0]        wb_data,
  output logic                   err_unready
);

  localparam int LAST = DEPTH - 1;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] we_q, we_d;
  logic [DEPTH-1:0] rdy_q, rdy_d;
  logic [AW-1:0]    rd_q   [DEPTH];
  logic [AW-1:0]    rd_d   [DEPTH];
  logic [XLEN-1:0]  data_q [DEPTH];
  logic [XLEN-1:0]  data_d [DEPTH];
  logic             err_q, err_d;

  logic [DEPTH-1:0] cap;
  logic [DEPTH-1:0] rdy_eff;
  logic [DEPTH-1:0] live;
  logic [XLEN-1:0]  data_eff [DEPTH];
  logic [NSRC-1:0]  haz;
  logic             issue_fire;
  logic             retire_ok;
  logic             retire_bad;

  // Per-stage view after this cycle's result capture and flush kill.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      assign cap[gi]      = valid_q[gi] & ~rdy_q[gi] & res_valid[gi];
      assign rdy_eff[gi]  = rdy_q[gi] | cap[gi];
      assign data_eff[gi] = cap[gi] ? res_data[gi*XLEN +: XLEN] : data_q[gi];
      assign live[gi]     = valid_q[gi] & ~(flush & (gi < FLUSH_STAGES));
    end
  endgenerate

  // Scanning from oldest to youngest lets the youngest match overwrite older ones.
  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_port
      logic [AW-1:0]   addr;
      logic            found;
      logic            m_rdy;
      logic [XLEN-1:0] m_data;

      assign addr = src_addr[gi*AW +: AW];

      always_comb begin
        found  = 1'b0;
        m_rdy  = 1'b0;
        m_data = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
          if (valid_q[k] && we_q[k] && (rd_q[k] == addr)) begin
            found  = 1'b1;
            m_rdy  = rdy_eff[k];
            m_data = data_eff[k];
          end
        end
        if (addr == '0) begin
          found = 1'b0;
        end
      end

      assign fwd_hit[gi]                = rst & found & m_rdy;
      assign fwd_data[gi*XLEN +: XLEN]  = m_data;
      assign haz[gi]                    = found & ~m_rdy;
    end
  endgenerate

  assign iss_ready  = rst & ~hold & ~(|haz);
  assign issue_fire = iss_valid & iss_ready & ~flush;

  assign retire_ok  = ~hold & valid_q[LAST] & we_q[LAST] & rdy_eff[LAST];
  assign retire_bad = ~hold & live[LAST] & we_q[LAST] & ~rdy_eff[LAST];

  assign wb_valid    = rst & retire_ok;
  assign wb_rd       = rd_q[LAST];
  assign wb_data     = data_eff[LAST];
  assign err_unready = err_q;

  // Under hold every stage keeps its entry but still absorbs captures and kills.
  always_comb begin
    valid_d = live;
    we_d    = we_q;
    rdy_d   = rdy_eff;
    rd_d    = rd_q;
    data_d  = data_eff;
    if (!hold) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        valid_d[k] = live[k-1];
        we_d[k]    = we_q[k-1];
        rdy_d[k]   = rdy_eff[k-1];
        rd_d[k]    = rd_q[k-1];
        data_d[k]  = data_eff[k-1];
      end
      valid_d[0] = issue_fire;
      we_d[0]    = issue_fire & iss_we & (iss_rd != '0);
      rdy_d[0]   = 1'b0;
      rd_d[0]    = issue_fire ? iss_rd : '0;
      data_d[0]  = '0;
    end
    err_d = err_q | retire_bad;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      we_q    <= '0;
      rdy_q   <= '0;
      err_q   <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        rd_q[k]   <= '0;
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_bypass_pipeline.sv
// Directed and randomized checks of bypass_pipeline against a stage-list reference model.
module tb_bypass_pipeline;
  localparam int XLEN = 32;
  localparam int DEPTH = 3;
  localparam int NSRC = 2;
  localparam int AW = 5;
  localparam int FS = 1;
  localparam int L = DEPTH - 1;

  logic                  clk;
  logic                  rst;
  logic                  hold;
  logic                  flush;
  logic                  iss_valid;
  logic                  iss_ready;
  logic                  iss_we;
  logic [AW-1:0]         iss_rd;
  logic [NSRC*AW-1:0]    src_addr;
  logic [NSRC-1:0]       fwd_hit;
  logic [NSRC*XLEN-1:0]  fwd_data;
  logic [DEPTH-1:0]      res_valid;
  logic [DEPTH*XLEN-1:0] res_data;
  logic                  wb_valid;
  logic [AW-1:0]         wb_rd;
  logic [XLEN-1:0]       wb_data;
  logic                  err_unready;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: one record per stage, index 0 youngest.
  logic            m_v    [DEPTH];
  logic            m_we   [DEPTH];
  logic            m_rdy  [DEPTH];
  logic [AW-1:0]   m_rd   [DEPTH];
  logic [XLEN-1:0] m_data [DEPTH];
  logic            m_err;

  logic            e_ready;
  logic            e_wb;
  logic [AW-1:0]   e_wbrd;
  logic [XLEN-1:0] e_wbdata;
  logic            e_hit [NSRC];
  logic [XLEN-1:0] e_fwd [NSRC];

  bypass_pipeline #(
    .XLEN(XLEN), .DEPTH(DEPTH), .NSRC(NSRC), .AW(AW), .FLUSH_STAGES(FS)
  ) dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_we(iss_we), .iss_rd(iss_rd),
    .src_addr(src_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .res_valid(res_valid), .res_data(res_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .err_unready(err_unready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] port_data(input int p);
    return fwd_data[p*XLEN +: XLEN];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) begin
      m_v[k] = 1'b0; m_we[k] = 1'b0; m_rdy[k] = 1'b0; m_rd[k] = '0; m_data[k] = '0;
    end
    m_err = 1'b0;
  endtask

  task automatic idle_inputs();
    iss_valid = 1'b0; iss_we = 1'b0; iss_rd = '0; src_addr = '0;
    res_valid = '0; res_data = '0; hold = 1'b0; flush = 1'b0;
  endtask

  task automatic set_res(input int k, input logic [XLEN-1:0] d);
    res_valid[k] = 1'b1;
    res_data[k*XLEN +: XLEN] = d;
  endtask

  task automatic issue(input logic [AW-1:0] rd, input logic we);
    iss_valid = 1'b1; iss_rd = rd; iss_we = we;
  endtask

  // Youngest in-flight producer of a register answers; a pending result is bypassed.
  task automatic model_expect();
    logic any_haz;
    any_haz = 1'b0;
    for (int p = 0; p < NSRC; p++) begin
      logic [AW-1:0] a;
      int fk;
      a = src_addr[p*AW +: AW];
      fk = -1;
      e_hit[p] = 1'b0;
      e_fwd[p] = '0;
      if (a != '0) begin
        for (int k = 0; k < DEPTH; k++)
          if (fk < 0 && m_v[k] && m_we[k] && m_rd[k] == a) fk = k;
      end
      if (fk >= 0) begin
        if (m_rdy[fk]) begin
          e_hit[p] = 1'b1; e_fwd[p] = m_data[fk];
        end else if (res_valid[fk]) begin
          e_hit[p] = 1'b1; e_fwd[p] = res_data[fk*XLEN +: XLEN];
        end else begin
          any_haz = 1'b1;
        end
      end
    end
    e_ready  = rst && !hold && !any_haz;
    e_wb     = rst && !hold && m_v[L] && m_we[L] && (m_rdy[L] || res_valid[L]);
    e_wbrd   = m_rd[L];
    e_wbdata = m_rdy[L] ? m_data[L] : res_data[L*XLEN +: XLEN];
  endtask

  task automatic check_model();
    model_expect();
    chk("m_iss_ready", 64'(iss_ready), 64'(e_ready));
    chk("m_wb_valid", 64'(wb_valid), 64'(e_wb));
    chk("m_err_unready", 64'(err_unready), 64'(m_err));
    for (int p = 0; p < NSRC; p++) begin
      chk($sformatf("m_fwd_hit%0d", p), 64'(fwd_hit[p]), 64'(e_hit[p]));
      if (e_hit[p]) chk($sformatf("m_fwd_data%0d", p), 64'(port_data(p)), 64'(e_fwd[p]));
    end
    if (e_wb) begin
      chk("m_wb_rd", 64'(wb_rd), 64'(e_wbrd));
      chk("m_wb_data", 64'(wb_data), 64'(e_wbdata));
    end
  endtask

  task automatic model_edge();
    logic fire;
    if (!rst) begin
      model_reset();
      return;
    end
    fire = iss_valid && e_ready && !flush;
    for (int k = 0; k < DEPTH; k++) begin
      if (m_v[k] && !m_rdy[k] && res_valid[k]) begin
        m_rdy[k] = 1'b1; m_data[k] = res_data[k*XLEN +: XLEN];
      end
    end
    if (!hold && m_v[L] && m_we[L] && !m_rdy[L]) m_err = 1'b1;
    if (flush) for (int k = 0; k < FS; k++) m_v[k] = 1'b0;
    if (!hold) begin
      for (int k = L; k > 0; k--) begin
        m_v[k] = m_v[k-1]; m_we[k] = m_we[k-1]; m_rdy[k] = m_rdy[k-1];
        m_rd[k] = m_rd[k-1]; m_data[k] = m_data[k-1];
      end
      m_v[0] = fire; m_we[0] = fire && iss_we && (iss_rd != '0);
      m_rdy[0] = 1'b0; m_rd[0] = fire ? iss_rd : '0; m_data[0] = '0;
    end
  endtask

  task automatic half();
    @(negedge clk);
    check_model();
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_cycle();
    idle_inputs();
    half();
    edge_step();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    model_reset();
    #2;
    chk("rst_iss_ready", 64'(iss_ready), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_fwd_hit", 64'(fwd_hit), 64'd0);
    chk("rst_err", 64'(err_unready), 64'd0);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // ALU chain: result at stage 0 forwarded to the next issue, retires 3 cycles later.
    idle_inputs(); issue(5'd5, 1'b1);
    half(); chk("t1_first_ready", 64'(iss_ready), 64'd1); edge_step();
    idle_inputs(); issue(5'd6, 1'b1); src_addr[0 +: AW] = 5'd5; set_res(0, 32'h11);
    half();
    chk("t1_hit", 64'(fwd_hit[0]), 64'd1);
    chk("t1_data", 64'(port_data(0)), 64'h11);
    chk("t1_ready", 64'(iss_ready), 64'd1);
    edge_step();
    idle_inputs(); set_res(0, 32'h66);
    half(); chk("t1_no_wb_early", 64'(wb_valid), 64'd0); edge_step();
    idle_inputs();
    half();
    chk("t1_wb_valid", 64'(wb_valid), 64'd1);
    chk("t1_wb_rd", 64'(wb_rd), 64'd5);
    chk("t1_wb_data", 64'(wb_data), 64'h11);
    edge_step();
    repeat (2) idle_cycle();

    // Load-use: one stall, then same-cycle bypass from stage 1.
    idle_inputs(); issue(5'd7, 1'b1); half(); edge_step();
    idle_inputs(); issue(5'd8, 1'b0); src_addr[AW +: AW] = 5'd7;
    half();
    chk("t2_stall", 64'(iss_ready), 64'd0);
    chk("t2_nohit", 64'(fwd_hit[1]), 64'd0);
    edge_step();
    set_res(1, 32'h2A);
    half();
    chk("t2_hit", 64'(fwd_hit[1]), 64'd1);
    chk("t2_data", 64'(port_data(1)), 64'h2A);
    chk("t2_ready", 64'(iss_ready), 64'd1);
    edge_step();
    idle_inputs();
    half();
    chk("t2_wb_rd", 64'(wb_rd), 64'd7);
    chk("t2_wb_data", 64'(wb_data), 64'h2A);
    edge_step();
    repeat (2) idle_cycle();

    // Youngest producer wins; x0 never hits.
    idle_inputs(); issue(5'd3, 1'b1); half(); edge_step();
    idle_inputs(); issue(5'd0, 1'b0); set_res(0, 32'hA); half(); edge_step();
    idle_inputs(); issue(5'd3, 1'b1); half(); edge_step();
    idle_inputs(); src_addr[0 +: AW] = 5'd3; src_addr[AW +: AW] = 5'd0; set_res(0, 32'hB);
    half();
    chk("t3_hit", 64'(fwd_hit[0]), 64'd1);
    chk("t3_data", 64'(port_data(0)), 64'hB);
    chk("t3_x0", 64'(fwd_hit[1]), 64'd0);
    chk("t3_old_wb", 64'(wb_data), 64'hA);
    edge_step();
    repeat (3) idle_cycle();

    // Hold: nothing retires, captures still land, order preserved afterwards.
    idle_inputs(); issue(5'd10, 1'b1); half(); edge_step();
    idle_inputs(); issue(5'd11, 1'b1); set_res(0, 32'h100); half(); edge_step();
    idle_inputs(); issue(5'd12, 1'b1); set_res(0, 32'h101); half(); edge_step();
    for (int h = 0; h < 4; h++) begin
      idle_inputs(); hold = 1'b1; src_addr[0 +: AW] = 5'd11;
      if (h == 1) set_res(0, 32'h102);
      if (h == 2) set_res(1, 32'hBAD);
      half();
      chk("t4_hold_wb", 64'(wb_valid), 64'd0);
      chk("t4_hold_ready", 64'(iss_ready), 64'd0);
      chk("t4_hold_data", 64'(port_data(0)), 64'h101);
      edge_step();
    end
    for (int r = 0; r < 3; r++) begin
      idle_inputs();
      half();
      chk("t4_wb_valid", 64'(wb_valid), 64'd1);
      chk("t4_wb_rd", 64'(wb_rd), 64'(10 + r));
      chk("t4_wb_data", 64'(wb_data), 64'(32'h100 + r));
      edge_step();
    end

    // Flush with a simultaneous issue: stage 0 and the new issue die, stage 1 retires.
    idle_inputs(); issue(5'd20, 1'b1); half(); edge_step();
    idle_inputs(); issue(5'd9, 1'b1); set_res(0, 32'h20); half(); edge_step();
    idle_inputs(); issue(5'd21, 1'b1); flush = 1'b1;
    half(); chk("t5_ready", 64'(iss_ready), 64'd1); edge_step();
    idle_inputs();
    half();
    chk("t5_wb_valid", 64'(wb_valid), 64'd1);
    chk("t5_wb_rd", 64'(wb_rd), 64'd20);
    edge_step();
    for (int r = 0; r < 2; r++) begin
      idle_inputs(); half(); chk("t5_no_wb", 64'(wb_valid), 64'd0); edge_step();
    end

    // Unready retire sets the sticky error; async reset clears outputs mid-cycle.
    idle_inputs(); issue(5'd30, 1'b1); half(); edge_step();
    idle_inputs(); issue(5'd31, 1'b1); half(); edge_step();
    idle_inputs(); set_res(0, 32'h31); half(); edge_step();
    idle_inputs(); half(); chk("t6_unready_wb", 64'(wb_valid), 64'd0); edge_step();
    idle_inputs(); src_addr[0 +: AW] = 5'd31;
    half();
    chk("t6_err", 64'(err_unready), 64'd1);
    chk("t6_wb_valid", 64'(wb_valid), 64'd1);
    chk("t6_wb_rd", 64'(wb_rd), 64'd31);
    chk("t6_hit", 64'(fwd_hit[0]), 64'd1);
    rst = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_wb", 64'(wb_valid), 64'd0);
    chk("t6_rst_ready", 64'(iss_ready), 64'd0);
    chk("t6_rst_hit", 64'(fwd_hit), 64'd0);
    chk("t6_rst_err", 64'(err_unready), 64'd0);
    edge_step();
    rst = 1'b1;
    for (int r = 0; r < 4; r++) begin
      idle_inputs(); half(); chk("t6_no_stale_wb", 64'(wb_valid), 64'd0); edge_step();
    end

    // Randomized traffic against the reference model.
    for (int it = 0; it < 500; it++) begin
      idle_inputs();
      rst       = ($urandom_range(0, 99) != 0);
      iss_valid = $urandom_range(0, 1) == 1;
      iss_we    = $urandom_range(0, 3) != 0;
      iss_rd    = AW'($urandom_range(0, 7));
      for (int p = 0; p < NSRC; p++) src_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
      for (int k = 0; k < DEPTH; k++) begin
        if ($urandom_range(0, 9) < 4) set_res(k, $urandom());
      end
      hold  = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 11) == 0);
      if (!rst) model_reset();
      half();
      edge_step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
